// File: rtl/prog_encoder.sv
// Control-flag bundle encoder: packs legal bundles into program words, buffers them in a
// 4-entry FIFO and streams them into program memory at sequential addresses.
module prog_encoder #(
    parameter int REG_W  = 3,
    parameter int IMM_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      alu_flag,
    input  logic                      ram_flag,
    input  logic                      alu_ctrl,
    input  logic                      bran,
    input  logic                      nw,
    input  logic                      mult_flag,
    input  logic [REG_W-1:0]          rd,
    input  logic [REG_W-1:0]          rs,
    input  logic [IMM_W-1:0]          imm,
    input  logic                      finish,
    input  logic                      restart,
    input  logic                      mem_busy,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [2+2*REG_W+IMM_W-1:0] wr_data,
    output logic                      illegal,
    output logic                      done,
    output logic [ADDR_W:0]           prog_len
);

    localparam int W = 2 + 2*REG_W + IMM_W;
    localparam logic [ADDR_W+1:0] DEPTH_V = (ADDR_W+2)'(2**ADDR_W);

    typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      fifo_mem [4];
    logic [1:0]        rd_ptr, wr_ptr;
    logic [2:0]        count;
    logic [ADDR_W:0]   wcnt;
    logic [ADDR_W+1:0] occ;
    logic [1:0]        opcode;
    logic              legal;
    logic              accept, push, pop;

    always_comb begin
        opcode = 2'd0;
        legal  = 1'b1;
        case ({alu_flag, ram_flag, alu_ctrl, bran, nw, mult_flag})
            6'b110000: opcode = 2'd0;
            6'b000000: opcode = 2'd1;
            6'b011001: opcode = 2'd2;
            6'b000110: opcode = 2'd3;
            default:   legal  = 1'b0;
        endcase
    end

    // Words already written plus words still queued must stay below memory depth.
    assign occ    = (ADDR_W+2)'(wcnt) + (ADDR_W+2)'(count);
    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = wr_en;

    always_ff @(posedge clk) begin
        if (reset || restart) state <= LOAD;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (finish) state_nxt = DRAIN;
            DRAIN:   if (count == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD) && (count != 3'd4) && (occ < DEPTH_V) && !restart;
        wr_en    = (state != DONE) && (count != 3'd0) && !mem_busy && !restart;
        done     = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
            count   <= 3'd0;
            wcnt    <= '0;
            illegal <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
                wcnt   <= wcnt + (ADDR_W+1)'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (accept && !legal) illegal <= 1'b1;
        end
    end

    // Storage is data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {opcode, rd, rs, imm};
    end

    assign wr_data  = fifo_mem[rd_ptr];
    assign wr_addr  = wcnt[ADDR_W-1:0];
    assign prog_len = wcnt;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: table of encode vectors plus hand-built sequences for
// back-pressure, depth limit, drain/done and restart/reset behaviour.
module tb_prog_encoder;

    logic        clk = 1'b0;
    logic        reset, in_valid, finish, restart, mem_busy;
    logic        alu_flag, ram_flag, alu_ctrl, bran, nw, mult_flag;
    logic [2:0]  rd, rs;
    logic [7:0]  imm;

    logic        in_ready, wr_en, illegal, done;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  prog_len;

    logic        s_in_ready, s_wr_en, s_illegal, s_done;
    logic [1:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic [2:0]  s_prog_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_flag(alu_flag), .ram_flag(ram_flag), .alu_ctrl(alu_ctrl), .bran(bran),
        .nw(nw), .mult_flag(mult_flag), .rd(rd), .rs(rs), .imm(imm),
        .finish(finish), .restart(restart), .mem_busy(mem_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .illegal(illegal), .done(done), .prog_len(prog_len)
    );

    prog_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .alu_flag(alu_flag), .ram_flag(ram_flag), .alu_ctrl(alu_ctrl), .bran(bran),
        .nw(nw), .mult_flag(mult_flag), .rd(rd), .rs(rs), .imm(imm),
        .finish(finish), .restart(restart), .mem_busy(mem_busy),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .illegal(s_illegal), .done(s_done), .prog_len(s_prog_len)
    );

    typedef struct {
        logic [5:0]  flags;
        logic [2:0]  vrd;
        logic [2:0]  vrs;
        logic [7:0]  vimm;
        logic        legal;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [10];
    logic [15:0] busy_words [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] c);
        {alu_flag, ram_flag, alu_ctrl, bran, nw, mult_flag} = f;
        rd = a;
        rs = b;
        imm = c;
        in_valid = 1'b1;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        {alu_flag, ram_flag, alu_ctrl, bran, nw, mult_flag} = 6'b0;
        rd = 3'd0;
        rs = 3'd0;
        imm = 8'd0;
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        logic sticky;

        vecs[0] = '{6'b110000, 3'd1, 3'd2, 8'h05, 1'b1, 16'h0A05};
        vecs[1] = '{6'b000000, 3'd7, 3'd0, 8'h10, 1'b1, 16'h7810};
        vecs[2] = '{6'b011001, 3'd3, 3'd5, 8'hAA, 1'b1, 16'h9DAA};
        vecs[3] = '{6'b000110, 3'd0, 3'd0, 8'hFF, 1'b1, 16'hC0FF};
        vecs[4] = '{6'b100100, 3'd1, 3'd1, 8'h01, 1'b0, 16'h0000};
        vecs[5] = '{6'b000000, 3'd2, 3'd3, 8'h3C, 1'b1, 16'h533C};
        vecs[6] = '{6'b111111, 3'd1, 3'd1, 8'h01, 1'b0, 16'h0000};
        vecs[7] = '{6'b010000, 3'd4, 3'd4, 8'h44, 1'b0, 16'h0000};
        vecs[8] = '{6'b110000, 3'd6, 3'd7, 8'h80, 1'b1, 16'h3780};
        vecs[9] = '{6'b000001, 3'd5, 3'd5, 8'h55, 1'b0, 16'h0000};
        busy_words[0] = 16'h4000;
        busy_words[1] = 16'h4801;
        busy_words[2] = 16'h5002;
        busy_words[3] = 16'h5803;

        reset = 1'b1; finish = 1'b0; restart = 1'b0; mem_busy = 1'b0;
        idle();
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_done", 32'(done), 0);
        check("rst_prog_len", 32'(prog_len), 0);
        reset = 1'b0;

        // Encode table: one bundle at a time, memory always free.
        n = 0;
        sticky = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].flags, vecs[i].vrd, vecs[i].vrs, vecs[i].vimm);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
            tick();
            idle();
            #1;
            sticky = sticky | !vecs[i].legal;
            check($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].legal));
            check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(sticky));
            if (vecs[i].legal) begin
                check($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(n));
                check($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].data));
                n++;
            end
            tick();
            check($sformatf("vec%0d_prog_len", i), 32'(prog_len), 32'(n));
        end

        // Back-to-back BRAN then IMM with simultaneous push and pop.
        do_restart();
        check("rst2_illegal", 32'(illegal), 0);
        check("rst2_prog_len", 32'(prog_len), 0);
        drive(6'b000110, 3'd0, 3'd0, 8'hFF);
        tick();
        drive(6'b000000, 3'd7, 3'd0, 8'h10);
        #1;
        check("seq_a_wr_addr", 32'(wr_addr), 0);
        check("seq_a_wr_data", 32'(wr_data), 32'hC0FF);
        tick();
        idle();
        #1;
        check("seq_b_wr_en", 32'(wr_en), 1);
        check("seq_b_wr_addr", 32'(wr_addr), 1);
        check("seq_b_wr_data", 32'(wr_data), 32'h7810);
        tick();
        check("seq_prog_len", 32'(prog_len), 2);
        check("seq_wr_en_idle", 32'(wr_en), 0);

        // Illegal bundle consumed, following legal word lands at address 0.
        do_restart();
        drive(6'b100100, 3'd1, 3'd2, 8'h05);
        #1;
        check("ill_in_ready", 32'(in_ready), 1);
        tick();
        idle();
        #1;
        check("ill_flag", 32'(illegal), 1);
        check("ill_wr_en", 32'(wr_en), 0);
        drive(6'b110000, 3'd1, 3'd2, 8'h05);
        tick();
        idle();
        #1;
        check("ill_next_wr_en", 32'(wr_en), 1);
        check("ill_next_wr_addr", 32'(wr_addr), 0);
        check("ill_next_wr_data", 32'(wr_data), 32'h0A05);
        check("ill_still_set", 32'(illegal), 1);
        tick();

        // Memory busy: FIFO fills at 4, then drains in order once released.
        do_restart();
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 3'(i), 3'd0, 8'(i));
            #1;
            check($sformatf("busy_in_ready%0d", i), 32'(in_ready), 32'(i < 4));
            check($sformatf("busy_wr_en%0d", i), 32'(wr_en), 0);
            check($sformatf("busy_wr_addr%0d", i), 32'(wr_addr), 0);
            tick();
        end
        idle();
        mem_busy = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rel_wr_en%0d", i), 32'(wr_en), 1);
            check($sformatf("rel_wr_addr%0d", i), 32'(wr_addr), 32'(i));
            check($sformatf("rel_wr_data%0d", i), 32'(wr_data), 32'(busy_words[i]));
            tick();
        end
        check("rel_wr_en_end", 32'(wr_en), 0);
        check("rel_prog_len", 32'(prog_len), 4);

        // Depth limit on the 4-word instance.
        do_restart();
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 3'(i), 3'd0, 8'(i));
            #1;
            check($sformatf("full_in_ready%0d", i), 32'(s_in_ready), 32'(i < 4));
            tick();
        end
        tick();
        #1;
        check("full_prog_len", 32'(s_prog_len), 4);
        check("full_in_ready_hold", 32'(s_in_ready), 0);
        check("full_wr_en", 32'(s_wr_en), 0);
        idle();
        do_restart();
        check("full_rst_prog_len", 32'(s_prog_len), 0);
        check("full_rst_in_ready", 32'(s_in_ready), 1);

        // Finish with words queued, drain to DONE, then reset.
        do_restart();
        mem_busy = 1'b1;
        drive(6'b000000, 3'd1, 3'd0, 8'h01);
        tick();
        drive(6'b000000, 3'd2, 3'd0, 8'h02);
        tick();
        idle();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        #1;
        check("drn_in_ready", 32'(in_ready), 0);
        check("drn_done0", 32'(done), 0);
        check("drn_wr_en_busy", 32'(wr_en), 0);
        mem_busy = 1'b0;
        #1;
        check("drn_w0_en", 32'(wr_en), 1);
        check("drn_w0_addr", 32'(wr_addr), 0);
        check("drn_w0_data", 32'(wr_data), 32'h4801);
        tick();
        check("drn_w1_en", 32'(wr_en), 1);
        check("drn_w1_addr", 32'(wr_addr), 1);
        check("drn_w1_data", 32'(wr_data), 32'h5002);
        check("drn_done1", 32'(done), 0);
        tick();
        check("drn_empty_wr_en", 32'(wr_en), 0);
        check("drn_done2", 32'(done), 0);
        check("drn_prog_len", 32'(prog_len), 2);
        tick();
        check("drn_done", 32'(done), 1);
        check("drn_done_in_ready", 32'(in_ready), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_done", 32'(done), 0);
        check("post_rst_prog_len", 32'(prog_len), 0);
        check("post_rst_in_ready", 32'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
